// File: rtl/riscv_scoreboard.sv
// Register scoreboard for in-order issue: tracks pending long-latency writes
// (loads/divides) and stalls decode on RAW, WAW or outstanding-capacity hazards.
module riscv_scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  logic        i_riscv_clk,
  input  logic        i_riscv_rst,
  input  logic        i_riscv_sb_issue_valid,
  input  logic [4:0]  i_riscv_sb_rs1addr,
  input  logic [4:0]  i_riscv_sb_rs2addr,
  input  logic        i_riscv_sb_rs1_used,
  input  logic        i_riscv_sb_rs2_used,
  input  logic [4:0]  i_riscv_sb_rdaddr,
  input  logic        i_riscv_sb_rd_wr,
  input  logic        i_riscv_sb_longop,
  input  logic        i_riscv_sb_done_valid,
  input  logic [4:0]  i_riscv_sb_done_rdaddr,
  input  logic        i_riscv_sb_flush,
  output logic        o_riscv_sb_stall,
  output logic        o_riscv_sb_issue_fire,
  output logic [31:0] o_riscv_sb_pending,
  output logic [2:0]  o_riscv_sb_count,
  output logic        o_riscv_sb_busy,
  output logic        o_riscv_sb_err
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUT);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] doneOneHot, rdOneHot, clrMask, effPending;
  logic        validDone, errEvent;
  logic        rs1Hazard, rs2Hazard, wawHazard, capHazard;
  logic        longReq, longIssue, issueOk;

  // A completion landing this cycle already resolves the hazard it clears.
  always_comb begin
    doneOneHot = 32'h1 << i_riscv_sb_done_rdaddr;
    rdOneHot   = 32'h1 << i_riscv_sb_rdaddr;
    clrMask    = i_riscv_sb_done_valid ? doneOneHot : 32'h0;
    effPending = pending_q & ~clrMask;

    validDone = i_riscv_sb_done_valid && (i_riscv_sb_done_rdaddr != 5'd0) &&
                pending_q[i_riscv_sb_done_rdaddr];
    errEvent  = i_riscv_sb_done_valid && !validDone;

    rs1Hazard = i_riscv_sb_rs1_used && (i_riscv_sb_rs1addr != 5'd0) &&
                effPending[i_riscv_sb_rs1addr];
    rs2Hazard = i_riscv_sb_rs2_used && (i_riscv_sb_rs2addr != 5'd0) &&
                effPending[i_riscv_sb_rs2addr];
    wawHazard = i_riscv_sb_rd_wr && (i_riscv_sb_rdaddr != 5'd0) &&
                effPending[i_riscv_sb_rdaddr];
    longReq   = i_riscv_sb_longop && i_riscv_sb_rd_wr && (i_riscv_sb_rdaddr != 5'd0);
    capHazard = longReq && (count_q == MaxOut) && !validDone;

    issueOk               = i_riscv_sb_issue_valid && !i_riscv_sb_flush;
    o_riscv_sb_stall      = issueOk && (rs1Hazard || rs2Hazard || wawHazard || capHazard);
    o_riscv_sb_issue_fire = issueOk && !o_riscv_sb_stall;
    longIssue             = o_riscv_sb_issue_fire && longReq;
  end

  // Clear first, then set, so a same-register set wins over a completion.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    err_d     = err_q || errEvent;
    if (validDone) begin
      pending_d = pending_d & ~doneOneHot;
    end
    if (longIssue) begin
      pending_d = pending_d | rdOneHot;
    end
    case ({longIssue, validDone})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst) begin
      pending_q <= 32'h0;
      count_q   <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign o_riscv_sb_pending = pending_q;
  assign o_riscv_sb_count   = count_q;
  assign o_riscv_sb_busy    = (count_q != 3'd0);
  assign o_riscv_sb_err     = err_q;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Directed scoreboard bench: each step queues expected stall/fire and post-edge
// state, then pops and compares them against the DUT.
module tb_riscv_scoreboard;

  logic        clk;
  logic        rstN;
  logic        issueValid;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr, doneAddr;
  logic        rs1Used, rs2Used, rdWr, longOp, doneValid, flush;
  logic        stall, issueFire, busy, err;
  logic [31:0] pending;
  logic [2:0]  count;

  int checkCount;
  int errorCount;
  string stepName;
  string tagQ[$];
  logic [31:0] valQ[$];

  riscv_scoreboard #(.MAX_OUT(4)) dut (
    .i_riscv_clk            (clk),
    .i_riscv_rst            (rstN),
    .i_riscv_sb_issue_valid (issueValid),
    .i_riscv_sb_rs1addr     (rs1Addr),
    .i_riscv_sb_rs2addr     (rs2Addr),
    .i_riscv_sb_rs1_used    (rs1Used),
    .i_riscv_sb_rs2_used    (rs2Used),
    .i_riscv_sb_rdaddr      (rdAddr),
    .i_riscv_sb_rd_wr       (rdWr),
    .i_riscv_sb_longop      (longOp),
    .i_riscv_sb_done_valid  (doneValid),
    .i_riscv_sb_done_rdaddr (doneAddr),
    .i_riscv_sb_flush       (flush),
    .o_riscv_sb_stall       (stall),
    .o_riscv_sb_issue_fire  (issueFire),
    .o_riscv_sb_pending     (pending),
    .o_riscv_sb_count       (count),
    .o_riscv_sb_busy        (busy),
    .o_riscv_sb_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s/%s: got 0x%08h, expected 0x%08h", stepName, tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] val);
    tagQ.push_back(tag);
    valQ.push_back(val);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    string t;
    logic [31:0] v;
    if (valQ.size() == 0) begin
      checkOutput("queue_empty", 32'd1, 32'd0);
    end else begin
      t = tagQ.pop_front();
      v = valQ.pop_front();
      checkOutput(t, observed, v);
    end
  endtask

  task automatic clearInputs();
    rstN       = 1'b1;
    issueValid = 1'b0;
    rs1Addr    = 5'd0;
    rs2Addr    = 5'd0;
    rs1Used    = 1'b0;
    rs2Used    = 1'b0;
    rdAddr     = 5'd0;
    rdWr       = 1'b0;
    longOp     = 1'b0;
    doneValid  = 1'b0;
    doneAddr   = 5'd0;
    flush      = 1'b0;
  endtask

  task automatic setLong(input logic [4:0] rd);
    issueValid = 1'b1;
    rdAddr     = rd;
    rdWr       = 1'b1;
    longOp     = 1'b1;
  endtask

  task automatic setDone(input logic [4:0] addr);
    doneValid = 1'b1;
    doneAddr  = addr;
  endtask

  // Inputs are set by the caller; this queues expectations and checks them.
  task automatic applyStimulus(input string name, input logic expStall, input logic expFire,
                               input logic [31:0] expPending, input logic [2:0] expCount,
                               input logic expErr);
    stepName = name;
    pushExpect("stall", {31'd0, expStall});
    pushExpect("issue_fire", {31'd0, expFire});
    #1;
    popCompare({31'd0, stall});
    popCompare({31'd0, issueFire});
    pushExpect("pending", expPending);
    pushExpect("count", {29'd0, expCount});
    pushExpect("busy", {31'd0, (expCount != 3'd0)});
    pushExpect("err", {31'd0, expErr});
    @(posedge clk);
    #1;
    popCompare(pending);
    popCompare({29'd0, count});
    popCompare({31'd0, busy});
    popCompare({31'd0, err});
    clearInputs();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    clearInputs();
    @(posedge clk);
    #1;

    // Reset with a hazard-free issue request: fire stays combinational.
    rstN = 1'b0; issueValid = 1'b1;
    applyStimulus("reset", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);

    // Load-use: ld x7 then add x4,x0,x7.
    setLong(5'd7);
    applyStimulus("ld_x7", 1'b0, 1'b1, 32'h80, 3'd1, 1'b0);
    issueValid = 1'b1; rs1Used = 1'b1; rs2Addr = 5'd7; rs2Used = 1'b1; rdAddr = 5'd4; rdWr = 1'b1;
    applyStimulus("use_x7_stall", 1'b1, 1'b0, 32'h80, 3'd1, 1'b0);
    issueValid = 1'b1; rs1Used = 1'b1; rs2Addr = 5'd7; rs2Used = 1'b1; rdAddr = 5'd4; rdWr = 1'b1;
    setDone(5'd7);
    applyStimulus("use_x7_done", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);

    // Same-cycle bypass on x9.
    setLong(5'd9);
    applyStimulus("ld_x9", 1'b0, 1'b1, 32'h200, 3'd1, 1'b0);
    issueValid = 1'b1; rs1Addr = 5'd9; rs1Used = 1'b1; rdAddr = 5'd10; rdWr = 1'b1;
    setDone(5'd9);
    applyStimulus("bypass_x9", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);

    // Capacity: four outstanding long-ops, the fifth waits for a done.
    for (int i = 1; i <= 4; i++) begin
      setLong(5'(i));
      applyStimulus($sformatf("ld_x%0d", i), 1'b0, 1'b1, (32'h2 << i) - 32'h2, 3'(i), 1'b0);
    end
    setLong(5'd5);
    applyStimulus("cap_stall", 1'b1, 1'b0, 32'h1E, 3'd4, 1'b0);
    setLong(5'd5); setDone(5'd2);
    applyStimulus("cap_release", 1'b0, 1'b1, 32'h3A, 3'd4, 1'b0);
    setDone(5'd1);
    applyStimulus("drain_x1", 1'b0, 1'b0, 32'h38, 3'd3, 1'b0);
    setDone(5'd3);
    applyStimulus("drain_x3", 1'b0, 1'b0, 32'h30, 3'd2, 1'b0);
    setDone(5'd4);
    applyStimulus("drain_x4", 1'b0, 1'b0, 32'h20, 3'd1, 1'b0);
    setDone(5'd5);
    applyStimulus("drain_x5", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);

    // Set wins over a same-register completion.
    setLong(5'd6);
    applyStimulus("ld_x6", 1'b0, 1'b1, 32'h40, 3'd1, 1'b0);
    setLong(5'd6); setDone(5'd6);
    applyStimulus("set_wins_x6", 1'b0, 1'b1, 32'h40, 3'd1, 1'b0);
    setDone(5'd6);
    applyStimulus("done_x6", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);

    // Flush suppresses issue; WAW stalls; completions apply under flush.
    setLong(5'd8); flush = 1'b1;
    applyStimulus("flush_ld_x8", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    setLong(5'd11);
    applyStimulus("ld_x11", 1'b0, 1'b1, 32'h800, 3'd1, 1'b0);
    issueValid = 1'b1; rdAddr = 5'd11; rdWr = 1'b1;
    applyStimulus("waw_x11", 1'b1, 1'b0, 32'h800, 3'd1, 1'b0);
    issueValid = 1'b1; rdAddr = 5'd11; rdWr = 1'b1; flush = 1'b1; setDone(5'd11);
    applyStimulus("flush_done_x11", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);

    // x0 destination and spurious done.
    setLong(5'd0);
    applyStimulus("ld_x0", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);
    setDone(5'd12);
    applyStimulus("bad_done_x12", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    applyStimulus("err_sticky", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);

    // Reset mid-operation with a completion and a hazard in flight.
    setLong(5'd5);
    applyStimulus("ld_x5", 1'b0, 1'b1, 32'h20, 3'd1, 1'b1);
    setLong(5'd6);
    applyStimulus("ld_x6b", 1'b0, 1'b1, 32'h60, 3'd2, 1'b1);
    setLong(5'd7);
    applyStimulus("ld_x7b", 1'b0, 1'b1, 32'hE0, 3'd3, 1'b1);
    rstN = 1'b0; setDone(5'd5); issueValid = 1'b1; rs1Addr = 5'd6; rs1Used = 1'b1;
    applyStimulus("reset_mid_op", 1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    applyStimulus("post_reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/riscv_scoreboard.md
RISCV_SCOREBOARD -- requirements
Module: riscv_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4, giving the maximum number of outstanding long-latency results (load/divide); legal range 1..7.
REQ-002 SHALL have port i_riscv_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_riscv_rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_riscv_sb_issue_valid, input, 1 bit: the decode stage holds an instruction requesting issue.
REQ-005 SHALL have ports i_riscv_sb_rs1addr and i_riscv_sb_rs2addr, input, 5 bits each: source register addresses.
REQ-006 SHALL have ports i_riscv_sb_rs1_used and i_riscv_sb_rs2_used, input, 1 bit each: the instruction reads that source.
REQ-007 SHALL have port i_riscv_sb_rdaddr, input, 5 bits: destination register address.
REQ-008 SHALL have port i_riscv_sb_rd_wr, input, 1 bit: the instruction writes rd.
REQ-009 SHALL have port i_riscv_sb_longop, input, 1 bit: the rd result is produced by a multi-cycle unit (load or div).
REQ-010 SHALL have ports i_riscv_sb_done_valid (input, 1 bit) and i_riscv_sb_done_rdaddr (input, 5 bits): a long-op result is written back this cycle.
REQ-011 SHALL have port i_riscv_sb_flush, input, 1 bit: squash the decode-stage instruction this cycle.
REQ-012 SHALL have port o_riscv_sb_stall, output, 1 bit: hold fetch/decode this cycle.
REQ-013 SHALL have port o_riscv_sb_issue_fire, output, 1 bit: the instruction issues this cycle.
REQ-014 SHALL have port o_riscv_sb_pending, output, 32 bits: per-register pending-write bits.
REQ-015 SHALL have port o_riscv_sb_count, output, 3 bits: number of outstanding long-ops.
REQ-016 SHALL have port o_riscv_sb_busy, output, 1 bit: count is nonzero.
REQ-017 SHALL have port o_riscv_sb_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 SHALL form the effective pending mask as eff = pending & ~clr, where clr is the one-hot of done_rdaddr when done_valid is 1 and zero otherwise; a same-cycle completion therefore resolves the hazard.
REQ-019 SHALL raise a RAW hazard when rsN_used is 1, rsN_addr is not 0 and eff[rsN_addr] is 1, for either source.
REQ-020 SHALL raise a WAW hazard when rd_wr is 1, rdaddr is not 0 and eff[rdaddr] is 1.
REQ-021 SHALL raise a capacity hazard when longop, rd_wr and rdaddr != 0 are all 1 and count equals MAX_OUT with no done this cycle.
REQ-022 SHALL compute stall = issue_valid & ~flush & (RAW | WAW | capacity), combinationally in the same cycle with zero latency.
REQ-023 SHALL compute issue_fire = issue_valid & ~flush & ~stall.
REQ-024 SHALL mark a long-op issue as the case where issue_fire, longop and rd_wr are 1 and rdaddr != 0; such an issue sets pending[rdaddr] on the next edge.
REQ-025 SHALL never set pending[0]; a long-op with rdaddr 0 neither increments count nor stalls on capacity.
REQ-026 SHALL clear pending[done_rdaddr] on the edge when done_valid is 1.
REQ-027 SHALL let set win when a set and a clear target the same register in the same cycle, so pending stays 1.
REQ-028 SHALL update count by +1 per long-op issue and -1 per valid done (done with a nonzero address on a pending register); simultaneous increment and decrement leaves count unchanged.
REQ-029 SHALL, when done_valid is 1 for a register whose pending bit is 0 (or for address 0), leave pending and count unchanged and set err, which remains 1 until reset.
REQ-030 SHALL give flush priority over issue: no state is set and stall is 0; completions in the same cycle are still applied.
REQ-031 SHALL drive busy = (count != 0).

Reset
REQ-032 SHALL, when i_riscv_rst is 0 at a rising edge, clear pending to 32'h0, count to 0 and err to 0; busy then reads 0.
REQ-033 SHALL drop any in-flight completions that arrive while reset is asserted.
REQ-034 SHALL keep stall and issue_fire combinational and gated by issue_valid even while reset is asserted.

Verification
REQ-035 SHALL cover load-use: issue ld x7 (longop, rd 7); next cycle add x4,x0,x7 -> stall is 1 and pending[7] is 1 until done_rdaddr 7, then fire in the done cycle; count goes 1->0.
REQ-036 SHALL cover same-cycle bypass: pending[9] is 1, done_rdaddr 9 and issue of rs1 9 in the same cycle -> stall is 0 and issue_fire is 1.
REQ-037 SHALL cover capacity: with MAX_OUT 4, issue 4 long-ops to x1..x4 and then a 5th to x5 -> stall is 1 and count is 4; done x2 -> the 5th fires in that cycle and count stays 4.
REQ-038 SHALL cover set-wins: pending[6] is 1, done x6 and issue of a long-op to x6 (WAW resolved by the done) -> pending[6] is 1 and count is unchanged.
REQ-039 SHALL cover x0 and error: a long-op to x0 -> pending is 0 and count is 0; done for x12 when it is not pending -> err is 1 and stays 1 until reset.
REQ-040 SHALL cover reset mid-operation: with count 3 and pending bits 0x000000E0, pull i_riscv_rst low for one edge -> pending is 0, count is 0 and busy is 0.
